// File: rtl/branch_predictor.sv
// Direct-mapped branch history/target table with combinational IF and EX lookups,
// one-cycle write-back of hazard-unit counter state, and saturating branch statistics.
module branch_predictor #(
  parameter int ADDR_SIZE  = 32,
  parameter int INDEX_BITS = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ADDR_SIZE-1:0] if_pc,
  output logic                 pred_hit,
  output logic                 pred_taken,
  output logic [ADDR_SIZE-1:0] pred_target,
  input  logic [ADDR_SIZE-1:0] ex_pc,
  output logic [1:0]           ex_state,
  input  logic                 upd_valid,
  input  logic [ADDR_SIZE-1:0] upd_pc,
  input  logic [1:0]           upd_new_state,
  input  logic [ADDR_SIZE-1:0] upd_target,
  input  logic                 upd_mispredict,
  output logic [31:0]          br_count,
  output logic [31:0]          mispred_count
);

  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam int TAG_W   = ADDR_SIZE - INDEX_BITS - 2;

  logic [ENTRIES-1:0]   valid_q, valid_d;
  logic [TAG_W-1:0]     tag_q    [ENTRIES];
  logic [TAG_W-1:0]     tag_d    [ENTRIES];
  logic [1:0]           state_q  [ENTRIES];
  logic [1:0]           state_d  [ENTRIES];
  logic [ADDR_SIZE-1:0] target_q [ENTRIES];
  logic [ADDR_SIZE-1:0] target_d [ENTRIES];
  logic [31:0]          br_count_q, br_count_d;
  logic [31:0]          mispred_count_q, mispred_count_d;

  logic [INDEX_BITS-1:0] if_idx, ex_idx, upd_idx;
  logic [TAG_W-1:0]      if_tag, ex_tag, upd_tag;
  logic                  if_hit, ex_hit;
  logic                  unused_pc_low;

  assign if_idx  = if_pc[INDEX_BITS+1:2];
  assign ex_idx  = ex_pc[INDEX_BITS+1:2];
  assign upd_idx = upd_pc[INDEX_BITS+1:2];
  assign if_tag  = if_pc[ADDR_SIZE-1:INDEX_BITS+2];
  assign ex_tag  = ex_pc[ADDR_SIZE-1:INDEX_BITS+2];
  assign upd_tag = upd_pc[ADDR_SIZE-1:INDEX_BITS+2];

  // Instruction-aligned PCs: the byte offset never selects anything.
  assign unused_pc_low = ^{if_pc[1:0], ex_pc[1:0], upd_pc[1:0]};

  always_comb begin
    if_hit      = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    ex_hit      = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
    pred_hit    = if_hit;
    pred_taken  = if_hit && state_q[if_idx][1];
    pred_target = if_hit ? target_q[if_idx] : '0;
    ex_state    = ex_hit ? state_q[ex_idx] : 2'b00;
  end

  always_comb begin
    valid_d         = valid_q;
    tag_d           = tag_q;
    state_d         = state_q;
    target_d        = target_q;
    br_count_d      = br_count_q;
    mispred_count_d = mispred_count_q;
    if (upd_valid) begin
      valid_d[upd_idx]  = 1'b1;
      tag_d[upd_idx]    = upd_tag;
      state_d[upd_idx]  = upd_new_state;
      target_d[upd_idx] = upd_target;
      if (br_count_q != 32'hFFFF_FFFF) begin
        br_count_d = br_count_q + 32'd1;
      end
      if (upd_mispredict && (mispred_count_q != 32'hFFFF_FFFF)) begin
        mispred_count_d = mispred_count_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q         <= '0;
      br_count_q      <= '0;
      mispred_count_q <= '0;
    end else begin
      valid_q         <= valid_d;
      br_count_q      <= br_count_d;
      mispred_count_q <= mispred_count_d;
    end
  end

  // Payload storage is harmless to write during reset since every valid bit clears.
  always_ff @(posedge clk) begin
    tag_q    <= tag_d;
    state_q  <= state_d;
    target_q <= target_d;
  end

  assign br_count      = br_count_q;
  assign mispred_count = mispred_count_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: a behavioural table model predicts each
// cycle's lookup outputs, which are queued at drive time and compared at sample time.
module tb_branch_predictor;

  typedef struct {
    logic        hit;
    logic        taken;
    logic [31:0] target;
    logic [1:0]  exs;
    logic [31:0] br;
    logic [31:0] mis;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] if_pc, ex_pc, upd_pc, upd_target;
  logic        upd_valid, upd_mispredict;
  logic [1:0]  upd_new_state;
  logic        pred_hit, pred_taken;
  logic [31:0] pred_target;
  logic [1:0]  ex_state;
  logic [31:0] br_count, mispred_count;

  int total = 0;
  int bad   = 0;

  logic        m_valid  [64];
  logic [23:0] m_tag    [64];
  logic [1:0]  m_state  [64];
  logic [31:0] m_target [64];
  logic [31:0] m_br, m_mis;
  exp_t        exp_q [$];

  branch_predictor #(.ADDR_SIZE(32), .INDEX_BITS(6)) dut (
    .clk(clk), .reset(reset),
    .if_pc(if_pc), .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
    .ex_pc(ex_pc), .ex_state(ex_state),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_new_state(upd_new_state),
    .upd_target(upd_target), .upd_mispredict(upd_mispredict),
    .br_count(br_count), .mispred_count(mispred_count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  function automatic exp_t modelLookup(input logic [31:0] ipc, input logic [31:0] epc);
    exp_t e;
    int ii = int'(ipc[7:2]);
    int ei = int'(epc[7:2]);
    e.hit    = m_valid[ii] && (m_tag[ii] == ipc[31:8]);
    e.taken  = e.hit && m_state[ii][1];
    e.target = e.hit ? m_target[ii] : 32'h0;
    e.exs    = (m_valid[ei] && (m_tag[ei] == epc[31:8])) ? m_state[ei] : 2'b00;
    e.br     = m_br;
    e.mis    = m_mis;
    return e;
  endfunction

  // Drive one cycle of inputs at the falling edge, queue the prediction, then compare.
  task automatic applyStimulus(input logic rst, input logic [31:0] ipc, input logic [31:0] epc,
                               input logic uv, input logic [31:0] upc, input logic [1:0] ust,
                               input logic [31:0] utgt, input logic umis);
    exp_t e;
    @(negedge clk);
    reset = rst; if_pc = ipc; ex_pc = epc;
    upd_valid = uv; upd_pc = upc; upd_new_state = ust; upd_target = utgt; upd_mispredict = umis;
    exp_q.push_back(modelLookup(ipc, epc));
    #1;
    if (exp_q.size() == 0) begin
      checkOutput("queueEmpty", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      checkOutput("sbHit",    {31'd0, pred_hit},     {31'd0, e.hit});
      checkOutput("sbTaken",  {31'd0, pred_taken},   {31'd0, e.taken});
      checkOutput("sbTarget", pred_target,           e.target);
      checkOutput("sbExState",{30'd0, ex_state},     {30'd0, e.exs});
      checkOutput("sbBr",     br_count,              e.br);
      checkOutput("sbMis",    mispred_count,         e.mis);
    end
  endtask

  // Advance through the rising edge and apply the same edge to the model.
  task automatic stepClock();
    int ui;
    @(posedge clk);
    ui = int'(upd_pc[7:2]);
    if (reset) begin
      for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
      m_br = 32'd0;
      m_mis = 32'd0;
    end else if (upd_valid) begin
      m_valid[ui]  = 1'b1;
      m_tag[ui]    = upd_pc[31:8];
      m_state[ui]  = upd_new_state;
      m_target[ui] = upd_target;
      if (m_br != 32'hFFFF_FFFF) m_br = m_br + 32'd1;
      if (upd_mispredict && m_mis != 32'hFFFF_FFFF) m_mis = m_mis + 32'd1;
    end
  endtask

  function automatic logic [31:0] pickPc();
    case ($urandom_range(0, 4))
      0: return 32'h0000_0100;
      1: return 32'h0000_0200;
      2: return 32'h0000_0104;
      3: return 32'h1000_0104;
      default: return {$urandom_range(0, 3), 2'b00} << 8 | ({24'd0, 6'($urandom_range(0, 63)), 2'b00});
    endcase
  endfunction

  initial begin
    reset = 1'b1; if_pc = 0; ex_pc = 0; upd_valid = 0; upd_pc = 0;
    upd_new_state = 0; upd_target = 0; upd_mispredict = 0;
    repeat (2) @(posedge clk);
    for (int i = 0; i < 64; i++) begin
      m_valid[i] = 1'b0; m_tag[i] = '0; m_state[i] = '0; m_target[i] = '0;
    end
    m_br = 0; m_mis = 0;

    applyStimulus(0, 32'h100, 32'h100, 0, 0, 2'b00, 0, 0);
    checkOutput("rstHit",   {31'd0, pred_hit}, 32'd0);
    checkOutput("rstTaken", {31'd0, pred_taken}, 32'd0);
    checkOutput("rstTgt",   pred_target, 32'd0);
    checkOutput("rstEx",    {30'd0, ex_state}, 32'd0);
    checkOutput("rstBr",    br_count, 32'd0);
    checkOutput("rstMis",   mispred_count, 32'd0);
    stepClock();

    applyStimulus(0, 32'h100, 32'h100, 1, 32'h100, 2'b10, 32'h80, 1);
    checkOutput("sameCycHit", {31'd0, pred_hit}, 32'd0);
    stepClock();
    applyStimulus(0, 32'h100, 32'h100, 0, 0, 2'b00, 0, 0);
    checkOutput("learnHit",   {31'd0, pred_hit}, 32'd1);
    checkOutput("learnTaken", {31'd0, pred_taken}, 32'd1);
    checkOutput("learnTgt",   pred_target, 32'h80);
    checkOutput("learnEx",    {30'd0, ex_state}, 32'd2);
    checkOutput("learnBr",    br_count, 32'd1);
    checkOutput("learnMis",   mispred_count, 32'd1);
    stepClock();

    applyStimulus(0, 32'h100, 32'h100, 1, 32'h100, 2'b01, 32'h84, 0);
    stepClock();
    applyStimulus(0, 32'h100, 32'h100, 0, 0, 2'b00, 0, 0);
    checkOutput("weakNtTaken", {31'd0, pred_taken}, 32'd0);
    checkOutput("weakNtEx",    {30'd0, ex_state}, 32'd1);
    stepClock();

    applyStimulus(0, 32'h100, 32'h100, 1, 32'h100, 2'b11, 32'h88, 0);
    stepClock();
    applyStimulus(0, 32'h100, 32'h100, 0, 0, 2'b00, 0, 0);
    checkOutput("weakTTaken", {31'd0, pred_taken}, 32'd1);
    stepClock();

    applyStimulus(0, 32'h100, 32'h100, 1, 32'h200, 2'b10, 32'h300, 0);
    stepClock();
    applyStimulus(0, 32'h100, 32'h200, 0, 0, 2'b00, 0, 0);
    checkOutput("aliasOldHit", {31'd0, pred_hit}, 32'd0);
    checkOutput("aliasNewEx",  {30'd0, ex_state}, 32'd2);
    stepClock();
    applyStimulus(0, 32'h200, 32'h100, 0, 0, 2'b00, 0, 0);
    checkOutput("aliasNewHit", {31'd0, pred_hit}, 32'd1);
    checkOutput("aliasNewTgt", pred_target, 32'h300);
    stepClock();

    for (int n = 0; n < 200; n++) begin
      applyStimulus(0, pickPc(), pickPc(), 1'($urandom_range(0, 1)), pickPc(),
                    2'($urandom_range(0, 3)), $urandom, 1'($urandom_range(0, 1)));
      stepClock();
    end

    #1;
    force dut.br_count_q = 32'hFFFF_FFFE;
    force dut.mispred_count_q = 32'hFFFF_FFFE;
    #1;
    release dut.br_count_q;
    release dut.mispred_count_q;
    m_br = 32'hFFFF_FFFE;
    m_mis = 32'hFFFF_FFFE;
    for (int n = 0; n < 3; n++) begin
      applyStimulus(0, 32'h100, 32'h100, 1, 32'h100 + 32'(n * 4), 2'b10, 32'h40, 1);
      stepClock();
    end
    applyStimulus(0, 32'h100, 32'h100, 0, 0, 2'b00, 0, 0);
    checkOutput("satBr",  br_count, 32'hFFFF_FFFF);
    checkOutput("satMis", mispred_count, 32'hFFFF_FFFF);
    stepClock();

    applyStimulus(1, 32'h100, 32'h100, 1, 32'h100, 2'b10, 32'h500, 1);
    stepClock();
    applyStimulus(0, 32'h100, 32'h100, 0, 0, 2'b00, 0, 0);
    checkOutput("rstWrHit", {31'd0, pred_hit}, 32'd0);
    checkOutput("rstWrEx",  {30'd0, ex_state}, 32'd0);
    checkOutput("rstWrBr",  br_count, 32'd0);
    checkOutput("rstWrMis", mispred_count, 32'd0);
    stepClock();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
